// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline freeze/flush sequencer.
package pipeline_hazard_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  typedef struct packed {
    logic freeze_if;
    logic freeze_pipe;
    logic flush_if;
    logic flush_id;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Fixed-priority sequencer for PC/IF freeze, pipe freeze, IF flush and ID->EX bubble,
// with saturating stall/flush event counters and a sticky memory-wait timeout.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               hazard_i,
  input  logic               branch_taken_i,
  input  logic               mem_req_i,
  input  logic               mem_ready_i,
  output logic               freeze_if_o,
  output logic               freeze_pipe_o,
  output logic               flush_if_o,
  output logic               flush_id_o,
  output logic               mem_timeout_o,
  output logic [CNT_W-1:0]   stall_count_o,
  output logic [CNT_W-1:0]   flush_count_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
  localparam int                FCNT_W     = 4;
  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              timeout_q, timeout_d;
  ctrl_t             ctrl;
  logic              flush_evt;
  logic              memwait;
  logic              wait_active;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  assign memwait     = mem_req_i & ~mem_ready_i;
  // A wait in FLUSH just parks the squash; only RUN/MEM_WAIT waits age toward timeout.
  assign wait_active = memwait & ((state_q == ST_RUN) | (state_q == ST_MEM_WAIT));

  always_comb begin
    ctrl      = '0;
    flush_evt = 1'b0;
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (memwait) begin
          ctrl.freeze_if   = 1'b1;
          ctrl.freeze_pipe = 1'b1;
          state_d          = ST_MEM_WAIT;
        end else if (branch_taken_i) begin
          ctrl.flush_if = 1'b1;
          ctrl.flush_id = 1'b1;
          flush_evt     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_d = ST_RUN;
          end
        end else if (hazard_i) begin
          ctrl.freeze_if = 1'b1;
          ctrl.flush_id  = 1'b1;
          state_d        = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (memwait) begin
          ctrl.freeze_if   = 1'b1;
          ctrl.freeze_pipe = 1'b1;
        end else begin
          ctrl.flush_if = 1'b1;
          ctrl.flush_id = 1'b1;
          fcnt_d        = fcnt_q - FCNT_W'(1);
          if (fcnt_q <= FCNT_W'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign timeout_d = timeout_q | (wait_active & (wait_cnt >= TIMEOUT_M1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_RUN;
      fcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Cleared on any non-wait cycle, so the first wait cycle leaves it at 1.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (CLK),
    .rst   (RST | ~wait_active),
    .inc   (wait_active),
    .count (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (ctrl.freeze_if),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (flush_evt),
    .count (flush_cnt)
  );

  // Outputs read as zero for the whole reset window, including before the first edge.
  assign freeze_if_o   = ctrl.freeze_if   & ~RST;
  assign freeze_pipe_o = ctrl.freeze_pipe & ~RST;
  assign flush_if_o    = ctrl.flush_if    & ~RST;
  assign flush_id_o    = ctrl.flush_id    & ~RST;
  assign mem_timeout_o = timeout_q        & ~RST;
  assign stall_count_o = RST ? '0 : stall_cnt;
  assign flush_count_o = RST ? '0 : flush_cnt;
  assign state_o       = RST ? '0 : state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, TIMEOUT=3, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             hazard_i = 1'b0, branch_taken_i = 1'b0, mem_req_i = 1'b0, mem_ready_i = 1'b0;
  logic             freeze_if_o, freeze_pipe_o, flush_if_o, flush_id_o, mem_timeout_o;
  logic [CNT_W-1:0] stall_count_o, flush_count_o;
  logic [1:0]       state_o;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(3), .CNT_W(CNT_W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .hazard_i       (hazard_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .freeze_if_o    (freeze_if_o),
    .freeze_pipe_o  (freeze_pipe_o),
    .flush_if_o     (flush_if_o),
    .flush_id_o     (flush_id_o),
    .mem_timeout_o  (mem_timeout_o),
    .stall_count_o  (stall_count_o),
    .flush_count_o  (flush_count_o),
    .state_o        (state_o)
  );

  always #5 CLK = ~CLK;

  // Packed observation: {fi, fp, fli, fid, to, state[1:0], stall[3:0], flush[3:0]}
  typedef struct {
    logic        rst, haz, br, req, rdy;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, haz, br, req, rdy,
                     input logic fi, fp, fli, fid, to,
                     input logic [1:0] st, input logic [3:0] sc, fc);
    vec_t v;
    v.rst = rst; v.haz = haz; v.br = br; v.req = req; v.rdy = rdy;
    v.exp = {fi, fp, fli, fid, to, st, sc, fc};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled shortly before the next rising edge.
  task automatic apply(input logic rst, haz, br, req, rdy);
    @(negedge CLK);
    RST = rst; hazard_i = haz; branch_taken_i = br; mem_req_i = req; mem_ready_i = rdy;
    #2;
  endtask

  function automatic logic [14:0] observe();
    return {freeze_if_o, freeze_pipe_o, flush_if_o, flush_id_o, mem_timeout_o,
            state_o, stall_count_o, flush_count_o};
  endfunction

  initial begin
    // reset, including active inputs that must stay masked
    add(1,0,0,0,0, 0,0,0,0,0, 0,0,0);
    add(1,1,1,1,0, 0,0,0,0,0, 0,0,0);
    // idle
    for (int i = 0; i < 10; i++) add(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    // hazard stall for two cycles
    add(0,1,0,0,0, 1,0,0,1,0, 0,0,0);
    add(0,1,0,0,0, 1,0,0,1,0, 0,1,0);
    add(0,0,0,0,0, 0,0,0,0,0, 0,2,0);
    // taken branch: three squash cycles, second branch ignored
    add(0,0,1,0,0, 0,0,1,1,0, 0,2,0);
    add(0,1,1,0,0, 0,0,1,1,0, 2,2,1);
    add(0,0,0,0,0, 0,0,1,1,0, 2,2,1);
    add(0,0,0,0,0, 0,0,0,0,0, 0,2,1);
    // four-cycle memory wait with hazard held; timeout fires after the third wait cycle
    add(0,1,0,1,0, 1,1,0,0,0, 0,2,1);
    add(0,1,0,1,0, 1,1,0,0,0, 1,3,1);
    add(0,1,0,1,0, 1,1,0,0,0, 1,4,1);
    add(0,1,0,1,0, 1,1,0,0,1, 1,5,1);
    add(0,1,0,1,1, 1,0,0,1,1, 1,6,1);
    add(0,0,0,0,0, 0,0,0,0,1, 0,7,1);
    // reset while in FLUSH with two squash cycles left
    add(0,0,1,0,0, 0,0,1,1,1, 0,7,1);
    add(1,1,1,0,0, 0,0,0,0,0, 0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    // five-cycle wait, branch held during freeze acted on once at release
    add(0,0,0,1,0, 1,1,0,0,0, 0,0,0);
    add(0,0,0,1,0, 1,1,0,0,0, 1,1,0);
    add(0,0,0,1,0, 1,1,0,0,0, 1,2,0);
    add(0,0,1,1,0, 1,1,0,0,1, 1,3,0);
    add(0,0,1,1,0, 1,1,0,0,1, 1,4,0);
    add(0,0,1,1,1, 0,0,1,1,1, 1,5,0);
    add(0,0,0,0,0, 0,0,1,1,1, 2,5,1);
    add(0,0,0,0,0, 0,0,1,1,1, 2,5,1);
    add(0,0,0,0,0, 0,0,0,0,1, 0,5,1);
    // memory wait inside FLUSH freezes and holds the squash count
    add(0,0,1,0,0, 0,0,1,1,1, 0,5,1);
    add(0,1,1,1,0, 1,1,0,0,1, 2,5,2);
    add(0,0,0,0,0, 0,0,1,1,1, 2,6,2);
    add(0,0,0,0,0, 0,0,1,1,1, 2,6,2);
    add(0,0,0,0,0, 0,0,0,0,1, 0,6,2);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].haz, vecs[i].br, vecs[i].req, vecs[i].rdy);
      check($sformatf("vec[%0d]", i), 32'(observe()), 32'(vecs[i].exp));
      if (freeze_if_o && flush_if_o)
        check($sformatf("excl[%0d]", i), 32'(1), 32'(0));
    end

    // stall counter saturation: 20 hazard cycles hold at 15
    apply(1,0,0,0,0);
    for (int i = 0; i < 20; i++) begin
      apply(0,1,0,0,0);
      check($sformatf("sat[%0d]", i), 32'(stall_count_o), 32'((i < 15) ? i : 15));
    end
    apply(0,0,0,0,0);
    check("sat_hold", 32'(stall_count_o), 32'(15));
    apply(0,1,0,0,0);
    apply(0,0,0,0,0);
    check("sat_nowrap", 32'(stall_count_o), 32'(15));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
